// File: rtl/pipeif_pkg.sv
// Shared constants for the instruction-fetch stage.
//   PCSRC_*   : redirect target select encodings (pcsource)
//   NOP_INS   : instruction presented when no entry is valid or an entry faulted
//   INS_W     : instruction field width of a queue entry
//   FAULT_W   : fault field width of a queue entry (1 when PIPEIF_FAULT_EN is defined, else 0)
//   entry_width(): total packed queue-entry width {fault, pc, pc4, ins}
// Configuration macro: PIPEIF_FAULT_EN.
package pipeif_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;  // refetch oldest unconsumed PC
  localparam logic [1:0] PCSRC_BR  = 2'b01;  // branch target
  localparam logic [1:0] PCSRC_REG = 2'b10;  // register (jr) target
  localparam logic [1:0] PCSRC_JMP = 2'b11;  // jump target

  localparam logic [31:0] NOP_INS = 32'h0;
  localparam int unsigned INS_W   = 32;

`ifdef PIPEIF_FAULT_EN
  localparam int unsigned FAULT_W = 1;
`else
  localparam int unsigned FAULT_W = 0;
`endif

  function automatic int unsigned entry_width(input int unsigned xlen);
    return FAULT_W + 2 * xlen + INS_W;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: Depth-entry circular buffer with head/tail pointers and an occupancy count.
//   clk_i, rst_i : clock, synchronous active-high reset (storage reloads ResetVal)
//   clear_i      : flush; dominates push_i/pop_i in the same cycle
//   push_i       : write wdata_i at tail (caller guarantees not full)
//   pop_i        : advance head (caller guarantees not empty)
//   rdata_o      : head entry (combinational from storage)
//   count_o      : number of valid entries
module fetch_fifo
  import pipeif_pkg::*;
#(
  parameter int unsigned      Depth    = 2,
  parameter int unsigned      Width    = 8,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [Width-1:0]           wdata_i,
  output logic [Width-1:0]           rdata_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) tail_d = ptr_inc(tail_q);
      if (pop_i)  head_d = ptr_inc(head_q);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= ResetVal;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_i && !clear_i) mem_q[tail_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/pipeif_prefetch.sv
// Instruction-fetch stage: PC register, 4-way redirect target select, synchronous ROM request
// and a DEPTH-entry prefetch queue of {pc, pc4, ins} handed to decode via valid/ready.
//   clock, reset        : clock (also clocks the ROM), synchronous active-high reset
//   redirect, pcsource  : flush queue and in-flight read, load target (00 refetch, 01 bpc,
//                         10 da, 11 jpc)
//   bpc, da, jpc        : candidate redirect targets
//   rom_addr, rom_rdata : ROM word address (from pc) and data returned one cycle later
//   id_valid, id_ready  : head-of-queue handshake with decode
//   id_ins, id_pc, id_pc4 : head entry (id_ins is NOP when !id_valid)
//   id_fault            : head fault flag, only with PIPEIF_FAULT_EN
// Configuration macro: PIPEIF_FAULT_EN (misaligned / out-of-ROM PCs fetch as faulted NOPs).
module pipeif_prefetch
  import pipeif_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ROM_AW   = 6,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect,
  input  logic [1:0]        pcsource,
  input  logic [XLEN-1:0]   bpc,
  input  logic [XLEN-1:0]   da,
  input  logic [XLEN-1:0]   jpc,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_ins,
  output logic [XLEN-1:0]   id_pc,
  output logic [XLEN-1:0]   id_pc4
`ifdef PIPEIF_FAULT_EN
  ,
  output logic              id_fault
`endif
);

  localparam int unsigned EntryW = entry_width(XLEN);
  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam int unsigned Pc4Lsb = INS_W;
  localparam int unsigned PcLsb  = INS_W + XLEN;

  localparam logic [XLEN-1:0] Four = XLEN'(4);

`ifdef PIPEIF_FAULT_EN
  localparam logic [EntryW-1:0] ResetEntry = {1'b0, RESET_PC, RESET_PC + Four, NOP_INS};
`else
  localparam logic [EntryW-1:0] ResetEntry = {RESET_PC, RESET_PC + Four, NOP_INS};
`endif

  logic [XLEN-1:0]   pc_q;
  logic              inflight_q;
  logic [XLEN-1:0]   inflight_pc_q;
  logic [XLEN-1:0]   target;
  logic [CntW-1:0]   fifo_count;
  logic [CntW:0]     occupancy;
  logic              issue, push, pop;
  logic [EntryW-1:0] push_entry, head_entry;
  logic [XLEN-1:0]   head_pc;

`ifdef PIPEIF_FAULT_EN
  logic inflight_fault_q;
  logic pc_fault;
  // Misaligned, or any bit above the ROM's reach set.
  assign pc_fault   = (pc_q[1:0] != 2'b00) | (|pc_q[XLEN-1:ROM_AW+2]);
  assign push_entry = {inflight_fault_q, inflight_pc_q, inflight_pc_q + Four,
                       inflight_fault_q ? NOP_INS : rom_rdata};
`else
  assign push_entry = {inflight_pc_q, inflight_pc_q + Four, rom_rdata};
`endif

  // Room is reserved for the in-flight read; a same-cycle pop is deliberately not credited.
  assign occupancy = {1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q};
  assign issue     = !redirect && (occupancy < (CntW + 1)'(DEPTH));
  assign push      = inflight_q && !redirect;
  assign pop       = id_valid && id_ready && !redirect;

  assign head_pc = head_entry[PcLsb +: XLEN];

  always_comb begin
    target = pc_q;
    case (pcsource)
      PCSRC_BR:  target = bpc;
      PCSRC_REG: target = da;
      PCSRC_JMP: target = jpc;
      default: begin
        // Oldest PC not yet handed to decode.
        if (fifo_count != '0)   target = head_pc;
        else if (inflight_q)    target = inflight_pc_q;
        else                    target = pc_q;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
    end else if (redirect) begin
      pc_q       <= target;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + Four;
      end
    end
  end

`ifdef PIPEIF_FAULT_EN
  always_ff @(posedge clock) begin
    if (reset)                   inflight_fault_q <= 1'b0;
    else if (!redirect && issue) inflight_fault_q <= pc_fault;
  end
`endif

  fetch_fifo #(
    .Depth    (DEPTH),
    .Width    (EntryW),
    .ResetVal (ResetEntry)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .clear_i (redirect),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .count_o (fifo_count)
  );

  assign rom_addr = pc_q[ROM_AW+1:2];
  assign id_valid = (fifo_count != '0);
  assign id_ins   = id_valid ? head_entry[INS_W-1:0] : NOP_INS;
  assign id_pc    = head_pc;
  assign id_pc4   = head_entry[Pc4Lsb +: XLEN];
`ifdef PIPEIF_FAULT_EN
  assign id_fault = id_valid & head_entry[EntryW-1];
`endif

endmodule

// File: tb/tb_pipeif_prefetch.sv
module tb_pipeif_prefetch;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ROM_AW = 6;
  localparam int unsigned DEPTH  = 2;

  logic              clock    = 1'b0;
  logic              reset    = 1'b1;
  logic              redirect = 1'b0;
  logic [1:0]        pcsource = 2'b00;
  logic [XLEN-1:0]   bpc      = '0;
  logic [XLEN-1:0]   da       = '0;
  logic [XLEN-1:0]   jpc      = '0;
  logic [ROM_AW-1:0] rom_addr;
  logic [31:0]       rom_rdata = '0;
  logic              id_valid;
  logic              id_ready = 1'b0;
  logic [31:0]       id_ins;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_pc4;
`ifdef PIPEIF_FAULT_EN
  logic              id_fault;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rom [64];

  pipeif_prefetch #(
    .XLEN     (XLEN),
    .ROM_AW   (ROM_AW),
    .DEPTH    (DEPTH),
    .RESET_PC ('0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .redirect  (redirect),
    .pcsource  (pcsource),
    .bpc       (bpc),
    .da        (da),
    .jpc       (jpc),
    .rom_addr  (rom_addr),
    .rom_rdata (rom_rdata),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id_ins    (id_ins),
    .id_pc     (id_pc),
    .id_pc4    (id_pc4)
`ifdef PIPEIF_FAULT_EN
    ,
    .id_fault  (id_fault)
`endif
  );

  always #5 clock = ~clock;

  // Synchronous ROM: address latched at the edge, data visible the following cycle.
  always @(posedge clock) rom_rdata <= rom[rom_addr];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench in cycle 0 (first cycle with reset low).
  task automatic do_reset(input logic ready);
    reset    = 1'b1;
    redirect = 1'b0;
    pcsource = 2'b00;
    id_ready = ready;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_tests++;
    if (id_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %0b want 0", id_valid);
    end
    n_tests++;
    if (id_ins !== 32'h0) begin
      n_fail++; $display("FAIL reset_ins: got %h want 00000000", id_ins);
    end
    n_tests++;
    if (id_pc !== 32'h0 || id_pc4 !== 32'h4) begin
      n_fail++; $display("FAIL reset_pc: got pc=%h pc4=%h want 0/4", id_pc, id_pc4);
    end
    n_tests++;
    if (rom_addr !== 6'd0) begin
      n_fail++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr);
    end
  endtask

  task automatic test_latency();
    int w;
    do_reset(1'b1);
    tick();  // cycle 1
    n_tests++;
    if (id_valid !== 1'b0 || rom_addr !== 6'd1) begin
      n_fail++; $display("FAIL lat_c1: got valid=%0b addr=%0d want 0/1", id_valid, rom_addr);
    end
    tick();  // cycle 2
    n_tests++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_ins !== 32'd1 || id_pc4 !== 32'h4) begin
      n_fail++;
      $display("FAIL lat_c2: got v=%0b pc=%h ins=%h pc4=%h want 1/0/1/4",
               id_valid, id_pc, id_ins, id_pc4);
    end
    tick();  // cycle 3
    n_tests++;
    if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_ins !== 32'd2) begin
      n_fail++; $display("FAIL lat_c3: got v=%0b pc=%h ins=%h want 1/4/2", id_valid, id_pc, id_ins);
    end
    tick();
    w = 0;
    while (!id_valid && w < 5) begin
      tick();
      w++;
    end
    n_tests++;
    if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_ins !== 32'd3) begin
      n_fail++; $display("FAIL lat_third: got v=%0b pc=%h ins=%h want 1/8/3", id_valid, id_pc, id_ins);
    end
  endtask

  task automatic test_stall();
    int exp_idx;
    do_reset(1'b0);
    repeat (10) tick();
    n_tests++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_ins !== 32'd1) begin
      n_fail++; $display("FAIL stall_head: got v=%0b pc=%h ins=%h want 1/0/1", id_valid, id_pc, id_ins);
    end
    // Exactly two lines issued (0, 4), so pc sits at 8.
    n_tests++;
    if (rom_addr !== 6'd2) begin
      n_fail++; $display("FAIL stall_issue_stop: got addr=%0d want 2", rom_addr);
    end
    id_ready = 1'b1;
    exp_idx  = 0;
    for (int c = 0; c < 30 && exp_idx < 5; c++) begin
      if (id_valid) begin
        n_tests++;
        if (id_pc !== 32'(exp_idx * 4) || id_ins !== 32'(exp_idx + 1)) begin
          n_fail++;
          $display("FAIL stall_order: got pc=%h ins=%h want pc=%h ins=%h",
                   id_pc, id_ins, 32'(exp_idx * 4), 32'(exp_idx + 1));
        end
        exp_idx++;
      end
      tick();
    end
    n_tests++;
    if (exp_idx != 5) begin
      n_fail++; $display("FAIL stall_drain: got %0d entries want 5", exp_idx);
    end
    id_ready = 1'b0;
  endtask

  task automatic test_redirect_br();
    do_reset(1'b0);
    repeat (6) tick();
    redirect = 1'b1;
    pcsource = 2'b01;
    bpc      = 32'h40;
    tick();  // r+1
    redirect = 1'b0;
    n_tests++;
    if (id_valid !== 1'b0 || rom_addr !== 6'd16) begin
      n_fail++; $display("FAIL br_r1: got v=%0b addr=%0d want 0/16", id_valid, rom_addr);
    end
    tick();  // r+2
    n_tests++;
    if (id_valid !== 1'b0) begin
      n_fail++; $display("FAIL br_r2: got v=%0b want 0", id_valid);
    end
    tick();  // r+3
    n_tests++;
    if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_ins !== 32'd17) begin
      n_fail++; $display("FAIL br_r3: got v=%0b pc=%h ins=%h want 1/40/17", id_valid, id_pc, id_ins);
    end
  endtask

  task automatic test_refetch();
    logic [1:0]  srcs [3];
    logic [31:0] want_pc [3];
    srcs[0] = 2'b00; want_pc[0] = 32'h08;
    srcs[1] = 2'b10; want_pc[1] = 32'h20;
    srcs[2] = 2'b11; want_pc[2] = 32'h30;
    da  = 32'h20;
    jpc = 32'h30;
    do_reset(1'b0);
    redirect = 1'b1;
    pcsource = 2'b01;
    bpc      = 32'h08;
    tick();
    redirect = 1'b0;
    repeat (5) tick();
    n_tests++;
    if (id_valid !== 1'b1 || id_pc !== 32'h08) begin
      n_fail++; $display("FAIL refetch_setup: got v=%0b pc=%h want 1/08", id_valid, id_pc);
    end
    for (int i = 0; i < 3; i++) begin
      redirect = 1'b1;
      pcsource = srcs[i];
      tick();
      redirect = 1'b0;
      tick();
      tick();
      n_tests++;
      if (id_valid !== 1'b1 || id_pc !== want_pc[i] || id_ins !== (want_pc[i] >> 2) + 32'd1) begin
        n_fail++;
        $display("FAIL refetch_src%0d: got v=%0b pc=%h ins=%h want 1/%h/%h", srcs[i],
                 id_valid, id_pc, id_ins, want_pc[i], (want_pc[i] >> 2) + 32'd1);
      end
      repeat (3) tick();
    end
  endtask

  task automatic test_redirect_push_pop();
    do_reset(1'b1);
    tick();
    tick();  // cycle 2: head pc0 being popped, pc4 arriving
    jpc      = 32'h80;
    redirect = 1'b1;
    pcsource = 2'b11;
    tick();
    redirect = 1'b0;
    n_tests++;
    if (id_valid !== 1'b0 || rom_addr !== 6'h20) begin
      n_fail++; $display("FAIL pp_r1: got v=%0b addr=%0d want 0/32", id_valid, rom_addr);
    end
    tick();
    tick();
    n_tests++;
    if (id_valid !== 1'b1 || id_pc !== 32'h80 || id_ins !== 32'h21) begin
      n_fail++; $display("FAIL pp_r3: got v=%0b pc=%h ins=%h want 1/80/21", id_valid, id_pc, id_ins);
    end
    tick();
    // Reset mid-stream, with a competing redirect that must lose.
    reset    = 1'b1;
    redirect = 1'b1;
    pcsource = 2'b01;
    bpc      = 32'h40;
    tick();
    redirect = 1'b0;
    n_tests++;
    if (id_valid !== 1'b0 || id_ins !== 32'h0 || id_pc !== 32'h0 || rom_addr !== 6'd0) begin
      n_fail++;
      $display("FAIL midreset: got v=%0b ins=%h pc=%h addr=%0d want 0/0/0/0",
               id_valid, id_ins, id_pc, rom_addr);
    end
    reset = 1'b0;  // cycle 0
    tick();
    n_tests++;
    if (id_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_c1: got v=%0b want 0", id_valid);
    end
    tick();
    n_tests++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_ins !== 32'd1) begin
      n_fail++; $display("FAIL midreset_c2: got v=%0b pc=%h ins=%h want 1/0/1", id_valid, id_pc, id_ins);
    end
  endtask

  task automatic test_fault();
    logic [31:0] want_ins;
    do_reset(1'b0);
    jpc      = 32'h102;
    redirect = 1'b1;
    pcsource = 2'b11;
    tick();
    redirect = 1'b0;
    tick();
    tick();
`ifdef PIPEIF_FAULT_EN
    want_ins = 32'h0;
    n_tests++;
    if (id_fault !== 1'b1) begin
      n_fail++; $display("FAIL fault_flag: got %0b want 1", id_fault);
    end
`else
    want_ins = 32'd1;  // 0x102 aliases onto ROM word 0
`endif
    n_tests++;
    if (id_valid !== 1'b1 || id_pc !== 32'h102 || id_pc4 !== 32'h106 || id_ins !== want_ins) begin
      n_fail++;
      $display("FAIL fault_entry: got v=%0b pc=%h pc4=%h ins=%h want 1/102/106/%h",
               id_valid, id_pc, id_pc4, id_ins, want_ins);
    end
    // PC + 4 wraps at the top of the address space.
    jpc      = 32'hFFFF_FFFC;
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    tick();
    tick();
`ifdef PIPEIF_FAULT_EN
    want_ins = 32'h0;
`else
    want_ins = 32'd64;
`endif
    n_tests++;
    if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC || id_pc4 !== 32'h0 || id_ins !== want_ins) begin
      n_fail++;
      $display("FAIL wrap_entry: got v=%0b pc=%h pc4=%h ins=%h want 1/fffffffc/0/%h",
               id_valid, id_pc, id_pc4, id_ins, want_ins);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'(i + 1);
    test_reset();
    test_latency();
    test_stall();
    test_redirect_br();
    test_refetch();
    test_redirect_push_pop();
    test_fault();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
